// File: rtl/pin_check_pkg.sv
// Shared types and constants for the pin-chain loopback checker.
package pin_check_pkg;

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, FINISH} state_t;
  typedef enum logic [2:0] {ZERO, ONE, WALK1, WALK0, PRBS} pat_kind_t;

  localparam int          SYNC_STAGES = 2;
  localparam logic [31:0] LFSR_SEED   = 32'hACE1_0001;
  // Galois form of x^32+x^22+x^2+x+1, shifting right
  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/pin_sync.sv
// Multi-flop synchroniser for asynchronous inputs; all stages reset to 0.
module pin_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] ff;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ff <= '0;
    else begin
      ff[0] <= d_i;
      for (int s = 1; s < STAGES; s++) ff[s] <= ff[s-1];
    end
  end

  assign q_o = ff[STAGES-1];

endmodule

// File: rtl/pin_chain_checker.sv
// Self-running loopback tester: drives pattern sequence, checks synchronised returns.
// Define PIN_CHECK_PRBS_EN to append PRBS_LEN LFSR patterns after the walk-0 set.
module pin_chain_checker
  import pin_check_pkg::*;
#(
  parameter int NUM_CH        = 17,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8,
  parameter int PRBS_LEN      = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              hold_i,
  input  logic [NUM_CH-1:0] in_i,
  output logic [NUM_CH-1:0] out_o,
  output logic              oe_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [NUM_CH-1:0] fail_mask_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

`ifdef PIN_CHECK_PRBS_EN
  localparam bit PRBS_EN = 1'b1;
`else
  localparam bit PRBS_EN = 1'b0;
`endif
  localparam int NUM_PAT  = 2*NUM_CH + 2 + (PRBS_EN ? PRBS_LEN : 0);
  localparam int PAT_W    = $clog2(NUM_PAT + 1);
  localparam int WAIT_CYC = SETTLE_CYCLES + SYNC_STAGES;
  localparam int WCNT_W   = $clog2(WAIT_CYC + 1);
  localparam int POP_W    = $clog2(NUM_CH + 1);
  localparam int SUM_W    = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  state_t            state, state_nx;
  pat_kind_t         kind;
  logic [PAT_W-1:0]  pat_idx, pat_sel, walk_bit;
  logic [WCNT_W-1:0] wait_cnt;
  logic [NUM_CH-1:0] in_sync, mism, mask_nx, one_hot, pat_val, prbs_val;
  logic [POP_W-1:0]  pop;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  err_nx;
  logic              last_pat;

  pin_sync #(.WIDTH(NUM_CH), .STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (in_i),
    .q_o   (in_sync)
  );

  assign last_pat = (pat_idx == PAT_W'(NUM_PAT - 1));
  assign busy_o   = (state == DRIVE) || (state == WAIT) || (state == CHECK);
  assign oe_o     = busy_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = DRIVE;
      DRIVE:   state_nx = WAIT;
      WAIT:    if (wait_cnt == '0) state_nx = CHECK;
      CHECK:   state_nx = last_pat ? FINISH : DRIVE;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (hold_i) state_nx = IDLE;
  end

  // Index of the pattern loaded on the next DRIVE entry
  assign pat_sel = (state == IDLE) ? '0 : pat_idx + PAT_W'(1);

  always_comb begin
    kind     = PRBS;
    walk_bit = '0;
    if (pat_sel == '0) kind = ZERO;
    else if (pat_sel == PAT_W'(1)) kind = ONE;
    else if (pat_sel < PAT_W'(2 + NUM_CH)) begin
      kind     = WALK1;
      walk_bit = pat_sel - PAT_W'(2);
    end else if (pat_sel < PAT_W'(2 + 2*NUM_CH)) begin
      kind     = WALK0;
      walk_bit = pat_sel - PAT_W'(2 + NUM_CH);
    end
  end

  assign one_hot = NUM_CH'(1) << walk_bit;

  always_comb begin
    case (kind)
      ZERO:    pat_val = '0;
      ONE:     pat_val = '1;
      WALK1:   pat_val = one_hot;
      WALK0:   pat_val = ~one_hot;
      default: pat_val = prbs_val;
    endcase
  end

`ifdef PIN_CHECK_PRBS_EN
  logic [31:0] lfsr;

  // Each PRBS pattern takes the current LFSR word, then the LFSR advances
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                        lfsr <= LFSR_SEED;
    else if (!hold_i && state == IDLE && start_i)     lfsr <= LFSR_SEED;
    else if (state_nx == DRIVE && kind == PRBS)       lfsr <= lfsr_step(lfsr);
  end

  assign prbs_val = lfsr[NUM_CH-1:0];
`else
  assign prbs_val = '0;
`endif

  assign mism    = in_sync ^ out_o;
  assign mask_nx = fail_mask_o | mism;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) pop = pop + POP_W'(mism[i]);
  end

  assign sum    = SUM_W'(err_cnt_o) + SUM_W'(pop);
  assign err_nx = (sum > SUM_W'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_o       <= '0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_mask_o <= '0;
      err_cnt_o   <= '0;
      pat_idx     <= '0;
      wait_cnt    <= '0;
    end else if (hold_i) begin
      // Partial mask/count stay visible for inspection after an abort
      done_o <= 1'b0;
      pass_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          fail_mask_o <= '0;
          err_cnt_o   <= '0;
          done_o      <= 1'b0;
          pass_o      <= 1'b0;
        end
        DRIVE: wait_cnt <= WCNT_W'(WAIT_CYC - 1);
        WAIT:  wait_cnt <= wait_cnt - WCNT_W'(1);
        CHECK: begin
          fail_mask_o <= mask_nx;
          err_cnt_o   <= err_nx;
          if (last_pat) begin
            done_o <= 1'b1;
            pass_o <= (mask_nx == '0);
          end
        end
        default: ;
      endcase
      if (state_nx == DRIVE) begin
        out_o   <= pat_val;
        pat_idx <= pat_sel;
      end
    end
  end

endmodule
